// File: rtl/mips32_pkg.sv
// Shared mips32 definitions: data-memory FSM state encoding, default word
// width and the load/store opcodes reused by the core.
package mips32_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ST = 2'd1,
    ACCESS  = 2'd2,
    RESP    = 2'd3
  } dmem_state_t;

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Load/store request and response channels between the MEM stage (master)
// and the data-memory responder (slave).
interface mips_dmem_responder_if #(
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mips_dmem_array.sv
// Single-port synchronous word array; contents are never reset.
// The read register only updates on an enabled load, so it holds its value otherwise.
module mips_dmem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder with WAIT wait states per access.
// Optional feature macro: DMEM_RANGE_CHECK_EN (flag addresses above the array).
module mips_dmem_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = mips32_pkg::DATA_W,
  parameter int WAIT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_dmem_responder_if.slave  bus,
  output logic                  busy
);
  import mips32_pkg::*;

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              we_q;
  logic              load_q;
  logic              err_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] arr_rdata;
  logic              in_range;
  logic              arr_en;

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = (addr_q[31:ADDR_W] == '0);
`else
  logic unused_hi;
  assign unused_hi = ^addr_q[31:ADDR_W];
  assign in_range  = 1'b1;
`endif

  // Control path: FSM, wait counter and response qualifiers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      load_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q <= bus.req_we;
            if (WAIT == 0) begin
              state <= ACCESS;
            end else begin
              cnt   <= 4'(WAIT - 1);
              state <= WAIT_ST;
            end
          end
        end
        WAIT_ST: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: begin
          load_q <= !we_q && in_range;
          err_q  <= !in_range;
          state  <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data capture at accept; no reset needed on the payload
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  assign arr_en = (state == ACCESS) && in_range;

  mips_dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (we_q),
    .addr  (addr_q[ADDR_W-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Load data is masked by a registered qualifier, so stores and errors read as 0
  assign bus.req_ready = (state == IDLE) && rst_n;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = load_q ? arr_rdata : '0;
  assign bus.rsp_err   = err_q;
  assign busy          = (state != IDLE);

endmodule
